xor_share_arbiter: RTL and testbench
====================================

Name: xor_share_arbiter

Overview:
- Shares one WIDTH-bit XOR datapath among NREQ requesters.
- Arbitration is round-robin. Each grant captures the winner's operand pair and returns A^B with the winner's ID on a valid/ready response port.
- Sits between several client blocks that each need occasional XOR results and the single shared XOR stage. Clients do not each instantiate their own XOR stage.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result width in bits.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; bit i high = requester i has a valid operand pair.
- a_in  in  NREQ*WIDTH  flattened A operands; requester i at [i*WIDTH +: WIDTH].
- b_in  in  NREQ*WIDTH  flattened B operands, same packing.
- gnt  out  NREQ  one-hot grant pulse, registered.
- rsp_valid  out  1  result valid.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  captured A^B.
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, ptr=0. Reset overrides everything, including an in-flight HOLD; the held result is discarded.
- State machine has two states, IDLE and HOLD.
- IDLE, req==0: remain in IDLE; all outputs keep rsp_valid=0 and gnt=0.
- IDLE, req!=0 at an edge:
  - winner w = first set bit of req, searching upward from index ptr with wrap-around modulo NREQ.
  - Next cycle: state=HOLD, rsp_valid=1, rsp_id=w, rsp_data = a_in[w] ^ b_in[w] (sampled at that edge), gnt = 1<<w for exactly one cycle.
- Latency: request sampled at edge N, result and grant visible after edge N.
- HOLD: rsp_valid, rsp_id and rsp_data stay stable while rsp_ready=0. gnt is 0 after the first HOLD cycle. No new arbitration occurs.
- HOLD, rsp_ready=1 at an edge: next cycle state=IDLE, rsp_valid=0, ptr=(w+1) mod NREQ. rsp_data and rsp_id may hold their last values.
- Handshake: the transfer happens on the edge where rsp_valid && rsp_ready.
- Throughput: at most one result per 2 cycles. IDLE always lasts at least one cycle between results.
- Requester protocol:
  - Hold req and operands stable until gnt[i] is seen.
  - Drop req (or present new operands) by the edge ending the gnt cycle.
  - Keeping req high after gnt is a new request.
- Changing operands while req is high and not yet granted is legal. The value sampled at the grant edge wins.
- Fairness: with all req held high, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ grants.
- ptr advances only on a completed response handshake, never on an idle cycle.
- Widths: rsp_data is exactly WIDTH bits with no extension. IDW is at least 1 for NREQ=2.

Decomposition:
- Package xor_arb_pkg holds:
  - the state enum {IDLE, HOLD};
  - default NREQ and WIDTH constants;
  - the IDW derivation.
- Sub-module rr_picker is purely combinational. Inputs: req and ptr. Outputs: winner index and an any flag.
- The top level holds the FSM, ptr, the capture registers and the XOR of the selected operand slices.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 → gnt=0000, rsp_valid=0, rsp_id=0, rsp_data=0x00. First grant after release goes to id 0.
- Single request: req=0010, a1=0xA5, b1=0x0F, rsp_ready=1 →
  - one cycle later: rsp_valid=1, rsp_id=1, rsp_data=0xAA, gnt=0010 for one cycle;
  - following cycle: rsp_valid=0.
- Round-robin: req=1111 held, each slot's a=i, b=0xF0, rsp_ready=1 → rsp_id sequence 0,1,2,3,0, one result every 2 cycles, rsp_data=0xF0,0xF1,0xF2,0xF3,0xF0.
- Backpressure: grant id 2 (a=0x3C, b=0xFF), rsp_ready=0 for 5 cycles →
  - rsp_valid=1, rsp_id=2, rsp_data=0xC3 stable throughout;
  - gnt high only in the first cycle; no other gnt;
  - rsp_ready=1 → rsp_valid=0 next cycle.
- Wrap priority: serve id 3, then req=1001 → id 0 granted next, then id 3 (ptr wraps 3→0→1).
- Reset mid-HOLD: rsp_valid=1 (id 1), rsp_ready=0, assert rst one cycle →
  - next cycle: rsp_valid=0, gnt=0, ptr=0;
  - with req=0100 pending after release: id 2 granted with a correct fresh result.

Source files
------------

// File: rtl/xor_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// xor_arb_pkg : shared state encoding and sizing helpers for xor_share_arbiter
// Revision    : 1.0
// ============================================================================
package xor_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    // An ID field must stay at least one bit wide even for two requesters.
    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xor_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// xor_share_arbiter_if : request/operand bundle and response port of the arbiter
// Revision             : 1.0
// ============================================================================
interface xor_share_arbiter_if
    import xor_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = id_width(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_ready;

    modport master (
        output req, a_in, b_in, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, a_in, b_in, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/xor_share_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational round-robin search, first set bit at or above ptr
// Revision  : 1.0
// ============================================================================
module rr_picker
    import xor_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    output logic      [IDW-1:0]  winner,
    output logic                 any
);
    localparam logic [IDW:0] c_nreq_w = NREQ[IDW:0];

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW:0]      w_sum;

    // Rotating a doubled copy puts requester ptr at bit 0, so the lowest set
    // bit of w_rot is the round-robin winner's offset from ptr.
    always_comb begin
        w_dbl  = {req, req} >> ptr;
        w_rot  = w_dbl[NREQ-1:0];
        any    = |w_rot;
        w_sum  = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_sum = {1'b0, ptr} + j[IDW:0];
            end
        end
        if (w_sum >= c_nreq_w) begin
            w_sum = w_sum - c_nreq_w;
        end
        winner = w_sum[IDW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/xor_share_arbiter.sv
`default_nettype none
// ============================================================================
// xor_share_arbiter : round-robin access to one shared XOR stage, result held
//                     on a valid/ready port until accepted
// Revision          : 1.0
// ============================================================================
module xor_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = id_width(NREQ)
) (
    input wire logic             clk,
    input wire logic             rst,
    xor_share_arbiter_if.slave   bus
);
    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic             r_valid;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_ptr;

    logic [IDW-1:0]   w_winner;
    logic             w_any;
    logic [WIDTH-1:0] w_xor;
    logic [NREQ-1:0]  w_onehot;
    logic [IDW-1:0]   w_ptr_next;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    always_comb begin
        w_xor    = '0;
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == i[IDW-1:0]) begin
                w_xor       = bus.a_in[i*WIDTH +: WIDTH] ^ bus.b_in[i*WIDTH +: WIDTH];
                w_onehot[i] = 1'b1;
            end
        end
        w_ptr_next = (r_id == c_last_id) ? '0 : r_id + 1'b1;
    end

    // Grant pulses only on the IDLE->HOLD edge; HOLD never re-arbitrates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= HOLD;
                        r_gnt   <= w_onehot;
                        r_valid <= 1'b1;
                        r_id    <= w_winner;
                        r_data  <= w_xor;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_xor_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_xor_share_arbiter : directed scoreboard bench for xor_share_arbiter
// Revision             : 1.0
// ============================================================================
module tb_xor_share_arbiter;
    import xor_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    xor_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    xor_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.a_in[i*WIDTH +: WIDTH] = a;
        bus.b_in[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input int id, input logic [WIDTH-1:0] data);
        exp_t e;
        e.id   = id[IDW-1:0];
        e.data = data;
        sb.push_back(e);
    endtask

    // First cycle of a response: pop the expected result and check it.
    task automatic check_grant(input string tag);
        exp_t            e;
        logic [NREQ-1:0] g;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=scoreboard_empty expected=pending_entry", tag);
        end else begin
            e = sb.pop_front();
            g = '0;
            g[e.id] = 1'b1;
            chk({tag, "_valid"}, bus.rsp_valid, 1);
            chk({tag, "_gnt"},   bus.gnt, g);
            chk({tag, "_id"},    bus.rsp_id, e.id);
            chk({tag, "_data"},  bus.rsp_data, e.data);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, bus.rsp_valid, 0);
        chk({tag, "_gnt"},   bus.gnt, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i[WIDTH-1:0], 8'hF0);

        // Reset held two cycles with all requests up
        tick();
        tick();
        check_idle("reset");
        chk("reset_id",   bus.rsp_id, 0);
        chk("reset_data", bus.rsp_data, 0);

        // Round-robin with all requests held, starting from id 0
        rst = 1'b0;
        push(0, 8'hF0); push(1, 8'hF1); push(2, 8'hF2); push(3, 8'hF3); push(0, 8'hF0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_grant($sformatf("rr%0d", k));
            if (k == 4) bus.req = 4'b0000;
            tick();
            check_idle($sformatf("rr%0d_gap", k));
        end

        // Single request from id 1 (ptr now 1)
        set_op(1, 8'hA5, 8'h0F);
        bus.req = 4'b0010;
        push(1, 8'hAA);
        tick();
        check_grant("single");
        bus.req = 4'b0000;
        tick();
        check_idle("single_done");

        // Backpressure on id 2; id 3 requests meanwhile but must wait
        set_op(2, 8'h3C, 8'hFF);
        bus.req       = 4'b0100;
        bus.rsp_ready = 1'b0;
        push(2, 8'hC3);
        tick();
        check_grant("bp_first");
        bus.req = 4'b1000;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("bp%0d_valid", k), bus.rsp_valid, 1);
            chk($sformatf("bp%0d_id", k),    bus.rsp_id, 2);
            chk($sformatf("bp%0d_data", k),  bus.rsp_data, 8'hC3);
            chk($sformatf("bp%0d_gnt", k),   bus.gnt, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_idle("bp_release");

        // Wrap priority: id 3, then with 1001 id 0 before id 3 again
        push(3, 8'hF3);
        tick();
        check_grant("wrap_id3");
        bus.req = 4'b1001;
        tick();
        check_idle("wrap_gap0");
        push(0, 8'hF0);
        tick();
        check_grant("wrap_id0");
        tick();
        check_idle("wrap_gap1");
        push(3, 8'hF3);
        tick();
        check_grant("wrap_id3b");
        bus.req = 4'b0000;
        tick();
        check_idle("wrap_done");

        // Reset while holding an unaccepted result for id 1
        set_op(1, 8'hA5, 8'h0F);
        bus.req       = 4'b0010;
        bus.rsp_ready = 1'b0;
        push(1, 8'hAA);
        tick();
        check_grant("mid_hold");
        bus.req = 4'b0000;
        rst     = 1'b1;
        tick();
        check_idle("mid_rst");
        chk("mid_rst_id",   bus.rsp_id, 0);
        chk("mid_rst_data", bus.rsp_data, 0);

        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        set_op(2, 8'h55, 8'h0F);
        bus.req = 4'b0100;
        push(2, 8'h5A);
        tick();
        check_grant("post_rst");
        bus.req = 4'b0000;
        tick();
        check_idle("post_rst_done");

        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
